// File: rtl/mtu_pkg.sv
// ============================================================================
// Module      : mtu_pkg
// Description : Shared types and constants for the MTU context-switch block.
//               Optional feature macro: MTU_CTXSW_VERIFY_EN (adds CHECK state).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mtu_pkg;

    localparam int unsigned CTX_W               = 4;
    localparam logic [31:0] MTU_CFG_ADR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
`ifdef MTU_CTXSW_VERIFY_EN
        ST_CHECK = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_e;

    // The status word sits directly after the last table entry.
    function automatic logic is_status_idx(input logic [CTX_W-1:0] idx,
                                           input int unsigned      nctx);
        return {1'b0, idx} == 5'(nctx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mtu_ctx_table.sv
// ============================================================================
// Module      : mtu_ctx_table
// Description : NCTX x 32 translation-base register file, byte-enable write,
//               two asynchronous read ports (slave side and sequencer side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtu_ctx_table
    import mtu_pkg::*;
#(
    parameter int unsigned NCTX = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [CTX_W-1:0] widx_i,
    input  logic [3:0]       wsel_i,
    input  logic [31:0]      wdat_i,
    input  logic [CTX_W-1:0] ridx_a_i,
    output logic [31:0]      rdat_a_o,
    input  logic [CTX_W-1:0] ridx_b_i,
    output logic [31:0]      rdat_b_o
);

    logic [31:0] mem_q [NCTX];

    for (genvar e = 0; e < NCTX; e++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mem_q[e] <= '0;
            end else if (we_i && (widx_i == CTX_W'(e))) begin
                for (int b = 0; b < 4; b++) begin
                    if (wsel_i[b]) begin
                        mem_q[e][8*b +: 8] <= wdat_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // Out-of-range indices read as zero.
    always_comb begin
        rdat_a_o = '0;
        rdat_b_o = '0;
        for (int i = 0; i < int'(NCTX); i++) begin
            if (ridx_a_i == CTX_W'(i)) rdat_a_o = mem_q[i];
            if (ridx_b_i == CTX_W'(i)) rdat_b_o = mem_q[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_mtu_ctxsw.sv
// ============================================================================
// Module      : wb_mtu_ctxsw
// Description : MTU context-switch sequencer: Wishbone slave context table plus
//               a Wishbone master that loads the selected base into the MTU.
//               Optional feature macro: MTU_CTXSW_VERIFY_EN (write readback).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mtu_ctxsw
    import mtu_pkg::*;
#(
    parameter int unsigned NCTX        = 8,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] MTU_CFG_ADR = MTU_CFG_ADR_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      s_adr_i,
    input  logic [31:0]      s_dat_i,
    output logic [31:0]      s_dat_o,
    input  logic [3:0]       s_sel_i,
    input  logic             s_we_i,
    input  logic             s_stb_i,
    input  logic             s_cyc_i,
    output logic             s_ack_o,
    input  logic             sw_req_i,
    input  logic [CTX_W-1:0] sw_ctx_i,
    output logic             sw_ack_o,
    output logic             sw_err_o,
    output logic             busy_o,
    output logic [CTX_W-1:0] cur_ctx_o,
    output logic [31:0]      m_adr_o,
    output logic [31:0]      m_dat_o,
    output logic [3:0]       m_sel_o,
    output logic             m_we_o,
    output logic             m_stb_o,
    output logic             m_cyc_o,
    input  logic             m_ack_i,
    input  logic [31:0]      m_dat_i
);

    state_e           state_q, state_d;
    logic [CTX_W-1:0] cur_ctx_q, cur_ctx_d;
    logic [CTX_W-1:0] req_ctx_q, req_ctx_d;
    logic [31:0]      m_dat_q, m_dat_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             m_cyc_q, m_cyc_d;
    logic             m_we_q, m_we_d;
    logic             sw_ack_q, sw_ack_d;
    logic             sw_err_q, sw_err_d;
    logic             s_ack_q;
    logic [31:0]      s_dat_q;

    logic [CTX_W-1:0] w_s_idx;
    logic             w_s_req;
    logic             w_s_in_tbl;
    logic [31:0]      w_tbl_s_rdat;
    logic [31:0]      w_tbl_sw_rdat;
    logic [31:0]      w_s_rdat;
    logic             w_tmo;
    logic             w_ctx_bad;
    logic             w_unused;

    assign w_s_idx    = s_adr_i[5:2];
    assign w_s_req    = s_cyc_i & s_stb_i & ~s_ack_q;
    assign w_s_in_tbl = {1'b0, w_s_idx} < 5'(NCTX);
    assign w_tmo      = (tmo_q == 8'(TIMEOUT - 1));
    assign w_ctx_bad  = {1'b0, sw_ctx_i} >= 5'(NCTX);
    assign w_unused   = ^{s_adr_i[31:6], s_adr_i[1:0]};

    mtu_ctx_table #(
        .NCTX (NCTX)
    ) u_table (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (w_s_req & s_we_i & w_s_in_tbl),
        .widx_i   (w_s_idx),
        .wsel_i   (s_sel_i),
        .wdat_i   (s_dat_i),
        .ridx_a_i (w_s_idx),
        .rdat_a_o (w_tbl_s_rdat),
        .ridx_b_i (sw_ctx_i),
        .rdat_b_o (w_tbl_sw_rdat)
    );

    always_comb begin
        w_s_rdat = '0;
        if (w_s_in_tbl) begin
            w_s_rdat = w_tbl_s_rdat;
        end else if (is_status_idx(w_s_idx, NCTX)) begin
            w_s_rdat = {27'b0, busy_o, cur_ctx_q};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_ack_q <= 1'b0;
            s_dat_q <= '0;
        end else begin
            s_ack_q <= w_s_req;
            if (w_s_req && !s_we_i) begin
                s_dat_q <= w_s_rdat;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cur_ctx_q <= '0;
            req_ctx_q <= '0;
            m_dat_q   <= '0;
            tmo_q     <= '0;
            m_cyc_q   <= 1'b0;
            m_we_q    <= 1'b0;
            sw_ack_q  <= 1'b0;
            sw_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_ctx_q <= cur_ctx_d;
            req_ctx_q <= req_ctx_d;
            m_dat_q   <= m_dat_d;
            tmo_q     <= tmo_d;
            m_cyc_q   <= m_cyc_d;
            m_we_q    <= m_we_d;
            sw_ack_q  <= sw_ack_d;
            sw_err_q  <= sw_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_ctx_d = cur_ctx_q;
        req_ctx_d = req_ctx_q;
        m_dat_d   = m_dat_q;
        tmo_d     = tmo_q;
        m_cyc_d   = m_cyc_q;
        m_we_d    = m_we_q;
        sw_ack_d  = 1'b0;
        sw_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sw_req_i) begin
                    if (w_ctx_bad) begin
                        sw_err_d = 1'b1;
                        state_d  = ST_DONE;
                    end else if (sw_ctx_i == cur_ctx_q) begin
                        sw_ack_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        // Base is captured here so later table writes cannot alter this switch.
                        req_ctx_d = sw_ctx_i;
                        m_dat_d   = w_tbl_sw_rdat;
                        tmo_d     = '0;
                        m_cyc_d   = 1'b1;
                        m_we_d    = 1'b1;
                        state_d   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                tmo_d = tmo_q + 8'd1;
                if (m_ack_i) begin
`ifdef MTU_CTXSW_VERIFY_EN
                    tmo_d   = '0;
                    m_we_d  = 1'b0;
                    state_d = ST_CHECK;
`else
                    m_cyc_d   = 1'b0;
                    m_we_d    = 1'b0;
                    cur_ctx_d = req_ctx_q;
                    sw_ack_d  = 1'b1;
                    state_d   = ST_DONE;
`endif
                end else if (w_tmo) begin
                    m_cyc_d  = 1'b0;
                    m_we_d   = 1'b0;
                    sw_err_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
`ifdef MTU_CTXSW_VERIFY_EN
            ST_CHECK: begin
                tmo_d = tmo_q + 8'd1;
                if (m_ack_i) begin
                    m_cyc_d = 1'b0;
                    state_d = ST_DONE;
                    if (m_dat_i == m_dat_q) begin
                        cur_ctx_d = req_ctx_q;
                        sw_ack_d  = 1'b1;
                    end else begin
                        sw_err_d = 1'b1;
                    end
                end else if (w_tmo) begin
                    m_cyc_d  = 1'b0;
                    sw_err_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_ack_o   = s_ack_q;
    assign s_dat_o   = s_dat_q;
    assign sw_ack_o  = sw_ack_q;
    assign sw_err_o  = sw_err_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign cur_ctx_o = cur_ctx_q;
    assign m_adr_o   = MTU_CFG_ADR;
    assign m_dat_o   = m_dat_q;
    assign m_sel_o   = 4'hF;
    assign m_we_o    = m_we_q;
    assign m_stb_o   = m_cyc_q;
    assign m_cyc_o   = m_cyc_q;

endmodule

`default_nettype wire
